// File: rtl/mac_pkg.sv
// Shared definitions for the mac_kern sequencer: beat size, channel limits,
// FSM state encoding and the beats-per-output helper.
package mac_pkg;

  localparam int N         = 16;
  localparam int MAX_IN_CH = 256;
  localparam int IN_CH_W   = $clog2(MAX_IN_CH);
  localparam int BEATS_W   = $clog2(MAX_IN_CH / N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  // Number of N-channel beats needed to cover in_ch channels; 0 encodes MAX_IN_CH.
  function automatic logic [BEATS_W-1:0] calc_beats(input logic [IN_CH_W-1:0] in_ch);
    logic [IN_CH_W:0] eff;
    logic [IN_CH_W:0] rounded;
    eff     = (in_ch == '0) ? (IN_CH_W+1)'(MAX_IN_CH) : {1'b0, in_ch};
    rounded = eff + (IN_CH_W+1)'(N - 1);
    return BEATS_W'(rounded / (IN_CH_W+1)'(N));
  endfunction

endpackage

// File: rtl/mac_vld_delay.sv
// Fixed-depth valid shift register that lines up mac_kern vld_i with the
// data coming back from the weight/feature buffers.
module mac_vld_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic vld_i,
  output logic vld_o
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  // Shift one stage per cycle regardless of backpressure; read data is already in flight.
  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = vld_i;
    for (int i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_o = sr_q[LAT-1];

endmodule

// File: rtl/mac_kern_sched.sv
// Tile sequencer for a single mac_kern: walks oc/pix/beat loops issuing
// buffer reads, aligns the MAC valid to buffer latency, and counts results.
module mac_kern_sched
  import mac_pkg::*;
#(
  parameter int PIX_W   = 12,
  parameter int OC_W    = 9,
  parameter int AW      = 14,
  parameter int BUF_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [IN_CH_W-1:0]  cfg_in_ch_i,
  input  logic                cfg_conv3x3_i,
  input  logic [PIX_W-1:0]    cfg_num_pix_i,
  input  logic [OC_W-1:0]     cfg_num_oc_i,
  input  logic                stall_i,
  output logic                idle_o,
  output logic                done_o,
  output logic                err_o,
  output logic                w_rd_en_o,
  output logic [AW-1:0]       w_rd_addr_o,
  output logic                f_rd_en_o,
  output logic [AW-1:0]       f_rd_addr_o,
  output logic [IN_CH_W-1:0]  mac_in_ch_o,
  output logic                mac_conv3x3_o,
  output logic                mac_vld_o,
  input  logic                mac_vld_i
);

  localparam int TOT_W = PIX_W + OC_W;

  state_e             state_q,   state_d;
  logic [IN_CH_W-1:0] in_ch_q,   in_ch_d;
  logic               conv_q,    conv_d;
  logic [PIX_W-1:0]   num_pix_q, num_pix_d;
  logic [OC_W-1:0]    num_oc_q,  num_oc_d;
  logic [BEATS_W-1:0] beats_q,   beats_d;
  logic [TOT_W-1:0]   total_q,   total_d;
  logic [BEATS_W-1:0] beat_q,    beat_d;
  logic [PIX_W-1:0]   pix_q,     pix_d;
  logic [OC_W-1:0]    oc_q,      oc_d;
  logic [TOT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               err_q,     err_d;

  logic        start_ok;
  logic        cfg_legal;
  logic        accept;
  logic        issue;
  logic        beat_last;
  logic        pix_last;
  logic        oc_last;
  logic        last_issue;
  logic [31:0] w_full;
  logic [31:0] f_full;

  assign start_ok   = start_i && (state_q == S_IDLE);
  assign cfg_legal  = (cfg_num_pix_i != '0) && (cfg_num_oc_i != '0);
  assign accept     = start_ok && cfg_legal;
  assign issue      = (state_q == S_ISSUE) && !stall_i;
  assign beat_last  = (beat_q == beats_q - 1'b1);
  assign pix_last   = (pix_q == num_pix_q - 1'b1);
  assign oc_last    = (oc_q == num_oc_q - 1'b1);
  assign last_issue = issue && beat_last && pix_last && oc_last;

  // Next-state logic: the tile finishes once every expected result has come back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (out_cnt_d == total_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command capture, loop counters (beat innermost, oc outermost) and result counting.
  always_comb begin
    in_ch_d   = in_ch_q;
    conv_d    = conv_q;
    num_pix_d = num_pix_q;
    num_oc_d  = num_oc_q;
    beats_d   = beats_q;
    total_d   = total_q;
    beat_d    = beat_q;
    pix_d     = pix_q;
    oc_d      = oc_q;
    out_cnt_d = out_cnt_q;
    err_d     = start_ok && !cfg_legal;

    if (accept) begin
      in_ch_d   = cfg_in_ch_i;
      conv_d    = cfg_conv3x3_i;
      num_pix_d = cfg_num_pix_i;
      num_oc_d  = cfg_num_oc_i;
      beats_d   = calc_beats(cfg_in_ch_i);
      total_d   = TOT_W'(cfg_num_pix_i) * TOT_W'(cfg_num_oc_i);
      beat_d    = '0;
      pix_d     = '0;
      oc_d      = '0;
      out_cnt_d = '0;
    end

    if (issue) begin
      if (beat_last) begin
        beat_d = '0;
        if (pix_last) begin
          pix_d = '0;
          oc_d  = oc_last ? '0 : oc_q + 1'b1;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    if ((state_q != S_IDLE) && mac_vld_i) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  // All sequencer state, cleared synchronously so a mid-tile reset aborts cleanly.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      in_ch_q   <= '0;
      conv_q    <= 1'b0;
      num_pix_q <= '0;
      num_oc_q  <= '0;
      beats_q   <= '0;
      total_q   <= '0;
      beat_q    <= '0;
      pix_q     <= '0;
      oc_q      <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ch_q   <= in_ch_d;
      conv_q    <= conv_d;
      num_pix_q <= num_pix_d;
      num_oc_q  <= num_oc_d;
      beats_q   <= beats_d;
      total_q   <= total_d;
      beat_q    <= beat_d;
      pix_q     <= pix_d;
      oc_q      <= oc_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign w_full = 32'(oc_q)  * 32'(beats_q) + 32'(beat_q);
  assign f_full = 32'(pix_q) * 32'(beats_q) + 32'(beat_q);

  assign idle_o        = (state_q == S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign w_rd_en_o     = issue;
  assign f_rd_en_o     = issue;
  assign w_rd_addr_o   = w_full[AW-1:0];
  assign f_rd_addr_o   = f_full[AW-1:0];
  assign mac_in_ch_o   = in_ch_q;
  assign mac_conv3x3_o = conv_q;

  mac_vld_delay #(
    .LAT (BUF_LAT)
  ) u_vld_delay (
    .clk   (clk),
    .rstn  (rstn),
    .vld_i (issue),
    .vld_o (mac_vld_o)
  );

endmodule

// File: tb/tb_mac_kern_sched.sv
// Directed bench for mac_kern_sched with a tiny mac_kern stand-in that
// returns one result per BEATS aligned valids.
module tb_mac_kern_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [7:0]  cfg_in_ch_i;
  logic        cfg_conv3x3_i;
  logic [11:0] cfg_num_pix_i;
  logic [8:0]  cfg_num_oc_i;
  logic        stall_i;
  logic        idle_o, done_o, err_o;
  logic        w_rd_en_o, f_rd_en_o;
  logic [13:0] w_rd_addr_o, f_rd_addr_o;
  logic [7:0]  mac_in_ch_o;
  logic        mac_conv3x3_o;
  logic        mac_vld_o;
  logic        mac_vld_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] in_ch;
    logic       conv;
    int         pix;
    int         oc;
    int         stall_from;
    int         stall_to;
    int         inj_cyc;
    int         beats;
    int         reads;
    int         w_sum;
    int         f_sum;
    int         w_last;
    int         f_last;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  mac_kern_sched #(
    .PIX_W   (12),
    .OC_W    (9),
    .AW      (14),
    .BUF_LAT (1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .cfg_in_ch_i   (cfg_in_ch_i),
    .cfg_conv3x3_i (cfg_conv3x3_i),
    .cfg_num_pix_i (cfg_num_pix_i),
    .cfg_num_oc_i  (cfg_num_oc_i),
    .stall_i       (stall_i),
    .idle_o        (idle_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .w_rd_en_o     (w_rd_en_o),
    .w_rd_addr_o   (w_rd_addr_o),
    .f_rd_en_o     (f_rd_en_o),
    .f_rd_addr_o   (f_rd_addr_o),
    .mac_in_ch_o   (mac_in_ch_o),
    .mac_conv3x3_o (mac_conv3x3_o),
    .mac_vld_o     (mac_vld_o),
    .mac_vld_i     (mac_vld_i)
  );

  task automatic applyStimulus(input logic st, input logic [7:0] in_ch, input logic conv,
                               input int pix, input int oc, input logic stall, input logic vld);
    start_i       = st;
    cfg_in_ch_i   = in_ch;
    cfg_conv3x3_i = conv;
    cfg_num_pix_i = 12'(pix);
    cfg_num_oc_i  = 9'(oc);
    stall_i       = stall;
    mac_vld_i     = vld;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_idle"},   int'(idle_o), 1);
    checkOutput({tag, "_done"},   int'(done_o), 0);
    checkOutput({tag, "_err"},    int'(err_o), 0);
    checkOutput({tag, "_rd_en"},  int'(w_rd_en_o) + int'(f_rd_en_o), 0);
    checkOutput({tag, "_addr"},   int'(w_rd_addr_o) + int'(f_rd_addr_o), 0);
    checkOutput({tag, "_in_ch"},  int'(mac_in_ch_o), 0);
    checkOutput({tag, "_conv"},   int'(mac_conv3x3_o), 0);
    checkOutput({tag, "_vld_o"},  int'(mac_vld_o), 0);
  endtask

  // Run one table tile to completion, tracing reads and returning results like mac_kern.
  task automatic runTile(input int idx);
    vec_t v;
    int ew[$], ef[$], gw[$], gf[$];
    int seq_err = 0, stall_err = 0, lag_err = 0, hold_err = 0, en_err = 0;
    int done_cnt = 0, done_cyc = -1, last_vld = -100, returned = 0;
    int mb = 0, w_sum = 0, f_sum = 0;
    logic pending = 1'b0, prev_rd = 1'b0, seen_done = 1'b0, stall, st, vld_now;
    logic [7:0] drive_in_ch;
    v = vecs[idx];
    for (int o = 0; o < v.oc; o++)
      for (int p = 0; p < v.pix; p++)
        for (int b = 0; b < v.beats; b++) begin
          ew.push_back(o * v.beats + b);
          ef.push_back(p * v.beats + b);
        end

    @(posedge clk); #1;
    applyStimulus(1'b1, v.in_ch, v.conv, v.pix, v.oc, 1'b0, 1'b0);
    #1;
    checkOutput($sformatf("t%0d_idle_at_start", idx), int'(idle_o), 1);

    for (int cyc = 1; cyc <= 600 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      stall       = (cyc >= v.stall_from) && (cyc <= v.stall_to);
      st          = (cyc == v.inj_cyc);
      drive_in_ch = st ? 8'd5 : v.in_ch;
      vld_now     = pending;
      pending     = 1'b0;
      applyStimulus(st, drive_in_ch, v.conv, v.pix, v.oc, stall, vld_now);
      #1;
      if (cyc == 1) begin
        checkOutput($sformatf("t%0d_busy", idx), int'(idle_o), 0);
        if (!stall) checkOutput($sformatf("t%0d_first_rd", idx), int'(w_rd_en_o), 1);
      end
      if (w_rd_en_o !== f_rd_en_o) en_err++;
      if (w_rd_en_o) begin
        gw.push_back(int'(w_rd_addr_o));
        gf.push_back(int'(f_rd_addr_o));
        if (stall) stall_err++;
      end
      if (mac_vld_o !== prev_rd) lag_err++;
      prev_rd = w_rd_en_o;
      if (mac_in_ch_o !== v.in_ch || mac_conv3x3_o !== v.conv) hold_err++;
      if (mac_vld_o) begin
        mb++;
        if (mb == v.beats) begin
          mb      = 0;
          pending = 1'b1;
        end
      end
      if (vld_now) begin
        returned++;
        last_vld = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc  = cyc;
        seen_done = 1'b1;
      end
    end

    @(posedge clk); #1;
    applyStimulus(1'b0, v.in_ch, v.conv, v.pix, v.oc, 1'b0, 1'b0);
    #1;
    if (done_o) done_cnt++;
    checkOutput($sformatf("t%0d_idle_after", idx), int'(idle_o), 1);

    if (gw.size() != ew.size()) seq_err++;
    for (int i = 0; i < gw.size(); i++) begin
      w_sum += gw[i];
      f_sum += gf[i];
      if (i < ew.size() && (gw[i] != ew[i] || gf[i] != ef[i])) seq_err++;
    end
    checkOutput($sformatf("t%0d_reads", idx), gw.size(), v.reads);
    checkOutput($sformatf("t%0d_w_sum", idx), w_sum, v.w_sum);
    checkOutput($sformatf("t%0d_f_sum", idx), f_sum, v.f_sum);
    checkOutput($sformatf("t%0d_w_last", idx), gw.size() > 0 ? gw[gw.size()-1] : -1, v.w_last);
    checkOutput($sformatf("t%0d_f_last", idx), gf.size() > 0 ? gf[gf.size()-1] : -1, v.f_last);
    checkOutput($sformatf("t%0d_addr_seq_err", idx), seq_err, 0);
    checkOutput($sformatf("t%0d_rd_during_stall", idx), stall_err, 0);
    checkOutput($sformatf("t%0d_vld_lag_err", idx), lag_err, 0);
    checkOutput($sformatf("t%0d_cfg_hold_err", idx), hold_err, 0);
    checkOutput($sformatf("t%0d_en_pair_err", idx), en_err, 0);
    checkOutput($sformatf("t%0d_returned", idx), returned, v.pix * v.oc);
    checkOutput($sformatf("t%0d_done_count", idx), done_cnt, 1);
    checkOutput($sformatf("t%0d_done_cycle", idx), done_cyc, last_vld + 1);
  endtask

  // Illegal command: one err pulse, no reads, never leaves idle.
  task automatic errTest(input int pix, input int oc, input string tag);
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'd16, 1'b0, pix, oc, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_err_same_cycle"}, int'(err_o), 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'd16, 1'b0, pix, oc, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_err_pulse"}, int'(err_o), 1);
    checkOutput({tag, "_idle"}, int'(idle_o), 1);
    checkOutput({tag, "_rd_en"}, int'(w_rd_en_o), 0);
    @(posedge clk); #2;
    checkOutput({tag, "_err_cleared"}, int'(err_o), 0);
    checkOutput({tag, "_rd_en_after"}, int'(w_rd_en_o), 0);
    checkOutput({tag, "_idle_after"}, int'(idle_o), 1);
  endtask

  initial begin
    int done_seen;
    //          in_ch conv pix oc sfrom sto inj beats reads wsum fsum wlast flast
    vecs[0] = '{8'd16, 1'b1, 2, 1, 0, 0, 0,  1,  2,   0,   1,   0,  1};
    vecs[1] = '{8'd64, 1'b0, 1, 2, 0, 0, 0,  4,  8,  28,  12,   7,  3};
    vecs[2] = '{8'd3,  1'b0, 3, 1, 0, 0, 0,  1,  3,   0,   3,   0,  2};
    vecs[3] = '{8'd0,  1'b1, 1, 1, 0, 0, 0, 16, 16, 120, 120,  15, 15};
    vecs[4] = '{8'd17, 1'b1, 2, 2, 0, 0, 0,  2,  8,  12,  12,   3,  3};
    vecs[5] = '{8'd64, 1'b0, 1, 2, 2, 4, 0,  4,  8,  28,  12,   7,  3};
    vecs[6] = '{8'd64, 1'b1, 1, 2, 0, 0, 3,  4,  8,  28,  12,   7,  3};

    rstn = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) runTile(i);

    errTest(4, 0, "err_oc0");
    errTest(0, 3, "err_pix0");

    // Abort a tile mid-issue and confirm a clean restart.
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'd64, 1'b1, 1, 2, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'd64, 1'b1, 1, 2, 1'b0, 1'b0);
    end
    #1;
    checkOutput("abort_rd_en_before_reset", int'(w_rd_en_o), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checkResetOutputs("abort");
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      if (done_o) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    runTile(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
